// File: rtl/sram_access_arbiter.sv
// rtl/sram_access_arbiter.sv - single-port SRAM arbiter: req 0 priority, round-robin rest, burst lock with forced yield
// Optional feature macro: SRAM_ARB_WPROT_EN (low-address write-protect window, sticky wprot_err_o).
module sram_access_arbiter #(
    parameter int NUM_REQ      = 3,
    parameter int READ_LATENCY = 3,
    parameter int MAX_LOCK     = 64
) (
    input  logic                  Clock_50,
    input  logic                  Reset,
    input  logic [NUM_REQ-1:0]    req_i,
    input  logic [NUM_REQ-1:0]    lock_i,
    input  logic [NUM_REQ-1:0]    we_n_i,
    input  logic [NUM_REQ*18-1:0] addr_i,
    input  logic [NUM_REQ*16-1:0] wdata_i,
    output logic [NUM_REQ-1:0]    gnt_o,
    output logic [NUM_REQ-1:0]    rvalid_o,
    output logic [15:0]           rdata_o,
    output logic [17:0]           SRAM_address_o,
    output logic [15:0]           SRAM_write_data_o,
    output logic                  SRAM_we_n_o,
    input  logic [15:0]           SRAM_read_data_i,
`ifdef SRAM_ARB_WPROT_EN
    input  logic [17:0]           wprot_limit_i,
    output logic                  wprot_err_o,
`endif
    output logic                  busy_o
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int CNT_W  = $clog2(MAX_LOCK + 1);
    localparam int DDEPTH = (READ_LATENCY > 1) ? READ_LATENCY - 1 : 1;

    typedef enum logic [1:0] {
        S_ARB_IDLE   = 2'd0,
        S_ARB_LOCKED = 2'd1,
        S_ARB_YIELD  = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [IDX_W-1:0]     owner;
    logic [IDX_W-1:0]     rr_ptr;
    logic [CNT_W-1:0]     lock_cnt;
    logic [CNT_W-1:0]     cnt_inc;

    logic                 idle_found;
    logic [IDX_W-1:0]     idle_win;
    logic                 hi_found;
    logic [IDX_W-1:0]     hi_win;
    logic                 lo_found;
    logic [IDX_W-1:0]     lo_win;
    logic                 arb_en;
    logic                 req_own;
    logic                 lock_own;

    logic                 gnt_any;
    logic [IDX_W-1:0]     gnt_idx;
    logic                 gnt_we_n;
    logic [17:0]          gnt_addr;
    logic [15:0]          gnt_wdata;
    logic                 issue_we_n;

    logic [NUM_REQ-1:0]   rv_pipe [READ_LATENCY];
    logic [15:0]          rd_pipe [DDEPTH];
    logic                 rd_inflight;

    assign req_own  = req_i[owner];
    assign lock_own = lock_i[owner];
    assign cnt_inc  = (lock_cnt == CNT_W'(MAX_LOCK)) ? lock_cnt : lock_cnt + CNT_W'(1);

    // Round-robin search over 1..NUM_REQ-1: lowest requester at/after rr_ptr, else lowest below it.
    always_comb begin
        hi_found = 1'b0;
        hi_win   = '0;
        lo_found = 1'b0;
        lo_win   = '0;
        for (int i = NUM_REQ - 1; i >= 1; i--) begin
            if (req_i[i]) begin
                if (i >= int'(rr_ptr)) begin
                    hi_found = 1'b1;
                    hi_win   = IDX_W'(i);
                end else begin
                    lo_found = 1'b1;
                    lo_win   = IDX_W'(i);
                end
            end
        end
        if (req_i[0]) begin
            idle_found = 1'b1;
            idle_win   = '0;
        end else if (hi_found) begin
            idle_found = 1'b1;
            idle_win   = hi_win;
        end else begin
            idle_found = lo_found;
            idle_win   = lo_win;
        end
    end

    always_ff @(posedge Clock_50 or posedge Reset) begin
        if (Reset) begin
            state    <= S_ARB_IDLE;
            owner    <= '0;
            rr_ptr   <= IDX_W'(1);
            lock_cnt <= '0;
        end else begin
            state <= state_next;
            if (arb_en) begin
                if (idle_found && idle_win != '0)
                    rr_ptr <= (idle_win == IDX_W'(NUM_REQ - 1)) ? IDX_W'(1) : idle_win + IDX_W'(1);
                if (idle_found && lock_i[idle_win]) begin
                    owner    <= idle_win;
                    lock_cnt <= CNT_W'(1);
                end else begin
                    lock_cnt <= '0;
                end
            end else if (state == S_ARB_LOCKED) begin
                lock_cnt <= cnt_inc;
            end else begin
                lock_cnt <= '0;
            end
        end
    end

    // A released lock (req or lock dropped) arbitrates as IDLE in the same cycle.
    always_comb begin
        state_next = state;
        arb_en     = 1'b0;
        case (state)
            S_ARB_IDLE: arb_en = 1'b1;
            S_ARB_LOCKED: begin
                if (!(req_own && lock_own))
                    arb_en = 1'b1;
                else if (owner != '0 && req_i[0] && cnt_inc == CNT_W'(MAX_LOCK))
                    state_next = S_ARB_YIELD;
            end
            S_ARB_YIELD: state_next = lock_own ? S_ARB_LOCKED : S_ARB_IDLE;
            default:     arb_en = 1'b1;
        endcase
        if (arb_en)
            state_next = (idle_found && lock_i[idle_win]) ? S_ARB_LOCKED : S_ARB_IDLE;
    end

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        if (arb_en) begin
            gnt_any = idle_found;
            gnt_idx = idle_win;
        end else if (state == S_ARB_LOCKED) begin
            gnt_any = 1'b1;
            gnt_idx = owner;
        end else if (state == S_ARB_YIELD) begin
            gnt_any = req_i[0];
        end
        gnt_o = '0;
        if (gnt_any)
            gnt_o[gnt_idx] = 1'b1;
    end

    always_comb begin
        gnt_we_n  = 1'b1;
        gnt_addr  = '0;
        gnt_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_o[i]) begin
                gnt_we_n  = we_n_i[i];
                gnt_addr  = addr_i[i*18 +: 18];
                gnt_wdata = wdata_i[i*16 +: 16];
            end
        end
    end

`ifdef SRAM_ARB_WPROT_EN
    logic wprot_hit;
    assign wprot_hit  = !gnt_we_n && (gnt_addr < wprot_limit_i);
    assign issue_we_n = gnt_we_n | wprot_hit;

    always_ff @(posedge Clock_50 or posedge Reset) begin
        if (Reset)
            wprot_err_o <= 1'b0;
        else if (wprot_hit)
            wprot_err_o <= 1'b1;
    end
`else
    assign issue_we_n = gnt_we_n;
`endif

    always_ff @(posedge Clock_50 or posedge Reset) begin
        if (Reset) begin
            SRAM_address_o    <= '0;
            SRAM_write_data_o <= '0;
            SRAM_we_n_o       <= 1'b1;
        end else if (gnt_any) begin
            SRAM_address_o    <= gnt_addr;
            SRAM_write_data_o <= gnt_wdata;
            SRAM_we_n_o       <= issue_we_n;
        end else begin
            SRAM_we_n_o       <= 1'b1;
        end
    end

    // Requester tags ride alongside; read data is captured the cycle after the address goes out.
    always_ff @(posedge Clock_50 or posedge Reset) begin
        if (Reset) begin
            for (int k = 0; k < READ_LATENCY; k++)
                rv_pipe[k] <= '0;
            for (int k = 0; k < DDEPTH; k++)
                rd_pipe[k] <= '0;
        end else begin
            rv_pipe[0] <= gnt_we_n ? gnt_o : '0;
            for (int k = 1; k < READ_LATENCY; k++)
                rv_pipe[k] <= rv_pipe[k-1];
            rd_pipe[0] <= SRAM_read_data_i;
            for (int k = 1; k < DDEPTH; k++)
                rd_pipe[k] <= rd_pipe[k-1];
        end
    end

    always_comb begin
        rd_inflight = 1'b0;
        for (int k = 0; k < READ_LATENCY; k++)
            rd_inflight = rd_inflight | (|rv_pipe[k]);
    end

    assign rvalid_o = rv_pipe[READ_LATENCY-1];
    assign rdata_o  = rd_pipe[DDEPTH-1];
    assign busy_o   = (state != S_ARB_IDLE) || rd_inflight;

endmodule
